// File: rtl/rst_seq_ctrl.sv
// Reset release sequencer.
// Holds all downstream domains in reset for a minimum time, then releases
// them one at a time in index order.  Each release waits for that domain's
// ready acknowledge plus an idle gap before the next one goes out.  A missing
// acknowledge or a lost ready re-asserts every domain and latches a sticky
// fault with the offending domain index.
module rst_seq_ctrl #(
    parameter int NUM_DOMAINS    = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8,
    localparam int IDX_W         = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SW_RST_REQ,
    input  logic [NUM_DOMAINS-1:0] DOMAIN_ACK,
    output logic [NUM_DOMAINS-1:0] DOMAIN_RST_N,
    output logic                   ALL_READY,
    output logic                   FAULT,
    output logic [IDX_W-1:0]       FAULT_IDX
);

    typedef enum logic [2:0] {
        S_HOLD,
        S_RELEASE,
        S_WAIT_ACK,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOMAINS - 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;

    logic                   cur_ack;
    logic [NUM_DOMAINS-1:0] rel_mask;
    logic                   any_drop;
    logic [IDX_W-1:0]       drop_idx;

    // Acknowledge of the domain currently being released, and its release bit.
    always_comb begin
        cur_ack  = DOMAIN_ACK[idx];
        rel_mask = NUM_DOMAINS'(1) << idx;
    end

    // Lowest-numbered domain whose ready has dropped (scan downward so the lowest wins).
    always_comb begin
        any_drop = 1'b0;
        drop_idx = '0;
        for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
            if (!DOMAIN_ACK[i]) begin
                any_drop = 1'b1;
                drop_idx = IDX_W'(i);
            end
        end
    end

    // Sequencer state machine; hardware and soft reset restart from HOLD with the fault cleared.
    always_ff @(posedge CLK) begin
        if (RST || SW_RST_REQ) begin
            state        <= S_HOLD;
            cnt          <= '0;
            idx          <= '0;
            DOMAIN_RST_N <= '0;
            ALL_READY    <= 1'b0;
            FAULT        <= 1'b0;
            FAULT_IDX    <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= S_RELEASE;
                    end
                    cnt <= cnt + 1'b1;
                end

                S_RELEASE: begin
                    DOMAIN_RST_N <= DOMAIN_RST_N | rel_mask;
                    cnt          <= '0;
                    state        <= S_WAIT_ACK;
                end

                S_WAIT_ACK: begin
                    if (cur_ack) begin
                        cnt <= '0;
                        if (idx == LAST_IDX) begin
                            ALL_READY <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state <= S_GAP;
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        FAULT        <= 1'b1;
                        FAULT_IDX    <= idx;
                        DOMAIN_RST_N <= '0;
                        ALL_READY    <= 1'b0;
                        state        <= S_FAULT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        idx   <= idx + 1'b1;
                        state <= S_RELEASE;
                    end
                    cnt <= cnt + 1'b1;
                end

                S_DONE: begin
                    if (any_drop) begin
                        FAULT        <= 1'b1;
                        FAULT_IDX    <= drop_idx;
                        DOMAIN_RST_N <= '0;
                        ALL_READY    <= 1'b0;
                        state        <= S_FAULT;
                    end
                end

                S_FAULT: begin
                    state <= S_FAULT;
                end

                default: begin
                    state        <= S_FAULT;
                    FAULT        <= 1'b1;
                    DOMAIN_RST_N <= '0;
                    ALL_READY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed testbench for the reset release sequencer.
// Runs with three domains, hold 4, gap 2, timeout 10.  Edge numbers in the
// checks count from the first edge after reset is released (edge 0).
module tb_rst_seq_ctrl;

    localparam int ND = 3;

    logic          CLK;
    logic          RST;
    logic          SW_RST_REQ;
    logic [ND-1:0] DOMAIN_ACK;
    logic [ND-1:0] DOMAIN_RST_N;
    logic          ALL_READY;
    logic          FAULT;
    logic [1:0]    FAULT_IDX;

    logic          ackTie;
    logic [ND-1:0] ackManual;
    int            edgeNum;
    int            checkCount;
    int            errorCount;

    rst_seq_ctrl #(
        .NUM_DOMAINS    (ND),
        .HOLD_CYCLES    (4),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (10),
        .CNT_W          (8)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .SW_RST_REQ   (SW_RST_REQ),
        .DOMAIN_ACK   (DOMAIN_ACK),
        .DOMAIN_RST_N (DOMAIN_RST_N),
        .ALL_READY    (ALL_READY),
        .FAULT        (FAULT),
        .FAULT_IDX    (FAULT_IDX)
    );

    // Acknowledge either follows the released resets or is driven by hand.
    assign DOMAIN_ACK = ackTie ? DOMAIN_RST_N : ackManual;

    // Free-running clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        edgeNum++;
    endtask

    task automatic runToEdge(input int n);
        while (edgeNum < n) tick();
    endtask

    task automatic applyStimulus(input logic rst, input logic sw,
                                 input logic tie, input logic [ND-1:0] ack);
        RST        = rst;
        SW_RST_REQ = sw;
        ackTie     = tie;
        ackManual  = ack;
    endtask

    // Apply one edge of RST, then restart edge numbering.
    task automatic applyReset(input logic tie, input logic [ND-1:0] ack);
        applyStimulus(1'b1, 1'b0, tie, ack);
        tick();
        RST     = 1'b0;
        edgeNum = -1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        edgeNum    = 0;
        applyStimulus(1'b1, 1'b0, 1'b1, '0);

        // Reset state
        applyReset(1'b1, '0);
        checkOutput("rst_rstn", 32'(DOMAIN_RST_N), 32'h0);
        checkOutput("rst_ready", 32'(ALL_READY), 32'h0);
        checkOutput("rst_fault", 32'(FAULT), 32'h0);
        checkOutput("rst_idx", 32'(FAULT_IDX), 32'h0);

        // Test 1: nominal sequence with ack tied to reset release
        runToEdge(3);  checkOutput("t1_e3", 32'(DOMAIN_RST_N), 32'h0);
        runToEdge(4);  checkOutput("t1_e4", 32'(DOMAIN_RST_N), 32'h1);
        runToEdge(7);  checkOutput("t1_e7", 32'(DOMAIN_RST_N), 32'h1);
        runToEdge(8);  checkOutput("t1_e8", 32'(DOMAIN_RST_N), 32'h3);
        runToEdge(11); checkOutput("t1_e11", 32'(DOMAIN_RST_N), 32'h3);
        runToEdge(12); checkOutput("t1_e12", 32'(DOMAIN_RST_N), 32'h7);
        checkOutput("t1_e12_ready", 32'(ALL_READY), 32'h0);
        runToEdge(13); checkOutput("t1_e13_ready", 32'(ALL_READY), 32'h1);
        checkOutput("t1_e13_fault", 32'(FAULT), 32'h0);

        // Test 3: drop ack[1] for one cycle while all domains are ready
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b101);
        tick();
        checkOutput("t3_fault", 32'(FAULT), 32'h1);
        checkOutput("t3_idx", 32'(FAULT_IDX), 32'h1);
        checkOutput("t3_rstn", 32'(DOMAIN_RST_N), 32'h0);
        checkOutput("t3_ready", 32'(ALL_READY), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b111);
        tick(); tick();
        checkOutput("t3_sticky", 32'(FAULT), 32'h1);
        checkOutput("t3_sticky_rstn", 32'(DOMAIN_RST_N), 32'h0);

        // Test 5a: soft reset clears the fault and the sequence reruns
        applyStimulus(1'b0, 1'b1, 1'b1, '0);
        tick();
        checkOutput("t5_sw_fault", 32'(FAULT), 32'h0);
        checkOutput("t5_sw_rstn", 32'(DOMAIN_RST_N), 32'h0);
        SW_RST_REQ = 1'b0;
        edgeNum = -1;
        runToEdge(3);  checkOutput("t5_e3", 32'(DOMAIN_RST_N), 32'h0);
        runToEdge(4);  checkOutput("t5_e4", 32'(DOMAIN_RST_N), 32'h1);
        runToEdge(8);  checkOutput("t5_e8", 32'(DOMAIN_RST_N), 32'h3);
        runToEdge(12); checkOutput("t5_e12", 32'(DOMAIN_RST_N), 32'h7);
        runToEdge(13); checkOutput("t5_e13_ready", 32'(ALL_READY), 32'h1);
        checkOutput("t5_e13_fault", 32'(FAULT), 32'h0);

        // Test 2: no acknowledge at all, domain 0 times out
        applyReset(1'b0, 3'b000);
        runToEdge(4);  checkOutput("t2_e4", 32'(DOMAIN_RST_N), 32'h1);
        runToEdge(13); checkOutput("t2_e13_fault", 32'(FAULT), 32'h0);
        checkOutput("t2_e13_rstn", 32'(DOMAIN_RST_N), 32'h1);
        runToEdge(14); checkOutput("t2_e14_fault", 32'(FAULT), 32'h1);
        checkOutput("t2_e14_idx", 32'(FAULT_IDX), 32'h0);
        checkOutput("t2_e14_rstn", 32'(DOMAIN_RST_N), 32'h0);
        runToEdge(30); checkOutput("t2_e30_fault", 32'(FAULT), 32'h1);
        checkOutput("t2_e30_rstn", 32'(DOMAIN_RST_N), 32'h0);

        // Test 4: soft reset while in the gap after domain 0 acknowledged
        applyReset(1'b1, '0);
        runToEdge(5);
        SW_RST_REQ = 1'b1;
        tick();
        checkOutput("t4_sw_rstn", 32'(DOMAIN_RST_N), 32'h0);
        checkOutput("t4_sw_ready", 32'(ALL_READY), 32'h0);
        SW_RST_REQ = 1'b0;
        edgeNum = -1;
        runToEdge(3);  checkOutput("t4_e3", 32'(DOMAIN_RST_N), 32'h0);
        runToEdge(4);  checkOutput("t4_e4", 32'(DOMAIN_RST_N), 32'h1);

        // Test 5b: RST and SW_RST_REQ together mid-sequence; no extra cycle
        runToEdge(9);
        applyStimulus(1'b1, 1'b1, 1'b1, '0);
        tick();
        checkOutput("t5b_rstn", 32'(DOMAIN_RST_N), 32'h0);
        checkOutput("t5b_fault", 32'(FAULT), 32'h0);
        checkOutput("t5b_ready", 32'(ALL_READY), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        edgeNum = -1;
        runToEdge(3);  checkOutput("t5b_e3", 32'(DOMAIN_RST_N), 32'h0);
        runToEdge(4);  checkOutput("t5b_e4", 32'(DOMAIN_RST_N), 32'h1);

        // Test 6: ack[1] arrives after 9 idle WAIT_ACK edges (edges 9..17), accepted on edge 18
        applyReset(1'b0, 3'b001);
        runToEdge(8);  checkOutput("t6_e8", 32'(DOMAIN_RST_N), 32'h3);
        runToEdge(17);
        ackManual = 3'b011;
        runToEdge(20); checkOutput("t6_e20", 32'(DOMAIN_RST_N), 32'h3);
        checkOutput("t6_e20_fault", 32'(FAULT), 32'h0);
        runToEdge(21); checkOutput("t6_e21", 32'(DOMAIN_RST_N), 32'h7);
        ackManual = 3'b111;
        runToEdge(22); checkOutput("t6_e22_ready", 32'(ALL_READY), 32'h1);
        checkOutput("t6_e22_fault", 32'(FAULT), 32'h0);

        // Test 6 sweep: one edge later is too late, domain 1 faults on edge 18
        applyReset(1'b0, 3'b001);
        runToEdge(17); checkOutput("t6s_e17_fault", 32'(FAULT), 32'h0);
        runToEdge(18); checkOutput("t6s_e18_fault", 32'(FAULT), 32'h1);
        checkOutput("t6s_e18_idx", 32'(FAULT_IDX), 32'h1);
        checkOutput("t6s_e18_rstn", 32'(DOMAIN_RST_N), 32'h0);
        ackManual = 3'b011;
        runToEdge(20); checkOutput("t6s_e20_fault", 32'(FAULT), 32'h1);
        checkOutput("t6s_e20_rstn", 32'(DOMAIN_RST_N), 32'h0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset release sequencer for the power-on and soft-reset path. It sits downstream of the reset synchronizer, whose output drives this block's RST. It holds every downstream domain in reset for a minimum time, then releases the domains one at a time in index order. Before releasing the next domain it waits for the current domain's ready acknowledge and a programmable gap. Acknowledge timeouts and ready losses are reported as a fault, and all domains are re-asserted.

Parameters:
NUM_DOMAINS, 4, number of sequenced reset domains (>=1)
HOLD_CYCLES, 16, minimum reset hold after RST/soft reset (>=1)
GAP_CYCLES, 8, idle cycles between an acknowledge and the next release (>=1)
TIMEOUT_CYCLES, 255, maximum cycles to wait for an acknowledge (>=1)
CNT_W, 8, shared counter width; must hold max(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)

Ports:
CLK  in  1  single clock
RST  in  1  synchronous, active-high reset
SW_RST_REQ  in  1  soft reset request, single-cycle pulse, active-high
DOMAIN_ACK  in  NUM_DOMAINS  per-domain ready acknowledge, level
DOMAIN_RST_N  out  NUM_DOMAINS  per-domain reset, active-low (0 = held in reset), registered
ALL_READY  out  1  all domains released and acknowledged, registered
FAULT  out  1  sequencing fault, sticky, registered
FAULT_IDX  out  $clog2(NUM_DOMAINS) (min 1)  domain index that caused the fault

Behaviour:
- Reset: RST=1 sampled on a CLK edge forces the following on that edge:
  - state=HOLD, counter=0, idx=0;
  - DOMAIN_RST_N=0, ALL_READY=0, FAULT=0, FAULT_IDX=0.
- Priority: RST > SW_RST_REQ > state logic.
- SW_RST_REQ=1 sampled in any state forces the same values as RST on that edge. Effect: restart from HOLD, fault cleared.
- Edge numbering: edge 0 is the first edge with RST=0 (and SW_RST_REQ=0). All outputs change only on edges.
- HOLD: counter increments each edge. On the edge where counter==HOLD_CYCLES-1, go to RELEASE.
- RELEASE (1 cycle): set DOMAIN_RST_N[idx]=1, clear counter, go to WAIT_ACK. DOMAIN_RST_N[0] therefore rises on edge HOLD_CYCLES.
- WAIT_ACK: sample DOMAIN_ACK[idx] only; other ACK bits are ignored.
  - ACK=1 and idx==NUM_DOMAINS-1: go to DONE, set ALL_READY=1.
  - ACK=1 and idx<NUM_DOMAINS-1: clear counter, go to GAP.
  - ACK=0: counter++. On the edge where counter==TIMEOUT_CYCLES-1 with ACK still 0, go to FAULT.
- GAP: counter increments. On the edge where counter==GAP_CYCLES-1: idx++, go to RELEASE. DOMAIN_RST_N[idx+1] rises GAP_CYCLES+1 edges after the acknowledging edge.
- DONE: ALL_READY=1, all DOMAIN_RST_N=1. If any DOMAIN_ACK bit is 0 on an edge, go to FAULT with FAULT_IDX = lowest index with ACK=0.
- FAULT: entered on an edge that sets:
  - FAULT=1, FAULT_IDX=idx (or the dropped index, when entered from DONE);
  - DOMAIN_RST_N=0, ALL_READY=0.
  The state is terminal; exit only via RST or SW_RST_REQ.
- Domains already released stay released during GAP/WAIT_ACK. Released bits never drop except on RST, SW_RST_REQ or FAULT.
- An ACK already high when WAIT_ACK is entered is accepted on the first WAIT_ACK edge.
- NUM_DOMAINS=1: no GAP state is ever visited.

Test Plan:
(NUM_DOMAINS=3, HOLD=4, GAP=2, TIMEOUT=10 unless stated)
1. Nominal sequence, DOMAIN_ACK tied to DOMAIN_RST_N.
   - Expected: DOMAIN_RST_N goes 001 after edge 4, 011 after edge 8, 111 after edge 12.
   - ALL_READY=1 after edge 13; FAULT stays 0.
2. Timeout on domain 0, DOMAIN_ACK=000 throughout.
   - Expected: DOMAIN_RST_N=001 after edge 4.
   - After edge 14: FAULT=1, FAULT_IDX=0, DOMAIN_RST_N=000, held indefinitely.
3. Ready loss in DONE: after ALL_READY=1, drop DOMAIN_ACK[1] for one cycle.
   - Expected: next edge FAULT=1, FAULT_IDX=1, DOMAIN_RST_N=000, ALL_READY=0.
4. Soft reset mid-sequence: pulse SW_RST_REQ while in GAP after domain 0 acknowledges.
   - Expected: next edge DOMAIN_RST_N=000, ALL_READY=0.
   - Sequence restarts; DOMAIN_RST_N[0] rises exactly 4 edges after the pulse is cleared.
5. Recovery from fault and priority check:
   - From FAULT, pulse SW_RST_REQ: FAULT=0, full sequence completes as in test 1.
   - Assert RST and SW_RST_REQ together: reset values result and no extra cycle is added.
6. Late acknowledge: ACK[1] asserted 9 cycles into WAIT_ACK.
   - Expected: no fault; DOMAIN_RST_N[2] rises GAP_CYCLES+1=3 edges after that edge.
   - Sweep: ACK at cycle 10 gives FAULT_IDX=1.
